// File: rtl/axiprotocol.sv
// axiprotocol: burst, response and FSM state encodings shared by the AXI write slave.
package axiprotocol;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// axi_wr_addr_gen: combinational next-beat byte address for FIXED, INCR and WRAP bursts.
module axi_wr_addr_gen
   import axiprotocol::*;
#(
   parameter int WIDTH = 32,
   parameter int SIZE  = 3
) (
   input  logic [WIDTH-1:0]   addr_i,
   input  logic [WIDTH/8-1:0] len_i,
   input  logic [SIZE-1:0]    size_i,
   input  logic [SIZE-2:0]    burst_i,
   output logic [WIDTH-1:0]   next_addr_o
);
   localparam int BW = SIZE - 1;

   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] incr;
   logic [WIDTH-1:0] window_mask;

   always_comb begin
      step        = WIDTH'(1) << size_i;
      incr        = addr_i + step;
      // WRAP window is (LEN+1) beats of 2^SIZE bytes, aligned to its own size
      window_mask = ((WIDTH'(len_i) + WIDTH'(1)) << size_i) - WIDTH'(1);
      next_addr_o = addr_i;
      if (burst_i == BW'(INCR)) begin
         next_addr_o = incr;
      end else if (burst_i == BW'(WRAP)) begin
         next_addr_o = (addr_i & ~window_mask) | (incr & window_mask);
      end
   end

endmodule

// File: rtl/axi_write_slave.sv
// axi_write_slave: single-outstanding AXI write slave backed by a DEPTH-word memory.
// AXI_WRAP_BURST_EN enables WRAP bursts; otherwise WRAP bursts are consumed and return SLVERR.
module axi_write_slave
   import axiprotocol::*;
#(
   parameter int WIDTH = 32,
   parameter int SIZE  = 3,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [WIDTH/8-1:0]       AWID,
   input  logic [WIDTH-1:0]         AWADDR,
   input  logic [WIDTH/8-1:0]       AWLEN,
   input  logic [SIZE-1:0]          AWSIZE,
   input  logic [SIZE-2:0]          AWBURST,
   input  logic                     WVALID,
   output logic                     WREADY,
   input  logic [WIDTH/8-1:0]       WID,
   input  logic [WIDTH-1:0]         WDATA,
   input  logic [WIDTH/8-1:0]       WSTRB,
   input  logic                     WLAST,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [WIDTH/8-1:0]       BID,
   output logic [SIZE-2:0]          BRESP,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [WIDTH-1:0]         dbg_rdata
);
   localparam int NB      = WIDTH / 8;
   localparam int BW      = SIZE - 1;
   localparam int AW      = $clog2(DEPTH);
   localparam int LANE_SH = $clog2(NB);

   state_e           state_q, state_d;
   logic [NB-1:0]    id_q, id_d, len_q, len_d, cnt_q, cnt_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [SIZE-1:0]  size_q, size_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic             err_q, err_d, dec_q, dec_d;
   logic             live_q;

   logic [WIDTH-1:0] next_addr, word_idx, merged;
   logic [AW-1:0]    mem_idx;
   logic             wrap_len_ok, aw_err, last_beat, beat_err, in_range, mem_we;
   resp_e            resp;

   logic [WIDTH-1:0] mem_q [DEPTH];

   axi_wr_addr_gen #(.WIDTH(WIDTH), .SIZE(SIZE)) u_addr_gen (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   assign wrap_len_ok = (AWLEN == NB'(1)) || (AWLEN == NB'(3)) ||
                        (AWLEN == NB'(7)) || (AWLEN == NB'(15));

   assign aw_err = (AWBURST == BW'(RSVD)) || (AWSIZE > SIZE'(LANE_SH)) ||
                   ((AWBURST == BW'(WRAP)) && !wrap_len_ok)
`ifndef AXI_WRAP_BURST_EN
                   || (AWBURST == BW'(WRAP))
`endif
                   ;

   assign last_beat = (cnt_q == len_q);
   assign beat_err  = (WID != id_q) || (WLAST != last_beat);
   assign word_idx  = addr_q >> LANE_SH;
   assign in_range  = word_idx < WIDTH'(DEPTH);
   assign mem_idx   = word_idx[AW-1:0];
   // A beat that itself breaks protocol is dropped along with the rest of the burst
   assign mem_we    = (state_q == DATA) && WVALID && !err_q && !beat_err && in_range;

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = WSTRB[gi] ? WDATA[gi*8 +: 8] : mem_q[mem_idx][gi*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= merged;
      end
   end

   assign dbg_rdata = mem_q[dbg_addr];

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      dec_d   = dec_q;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      case (state_q)
         IDLE: begin
            AWREADY = live_q;
            if (AWVALID && live_q) begin
               id_d    = AWID;
               addr_d  = AWADDR;
               len_d   = AWLEN;
               size_d  = AWSIZE;
               burst_d = AWBURST;
               cnt_d   = '0;
               err_d   = aw_err;
               dec_d   = 1'b0;
               state_d = DATA;
            end
         end
         DATA: begin
            WREADY = 1'b1;
            if (WVALID) begin
               cnt_d  = cnt_q + NB'(1);
               addr_d = next_addr;
               err_d  = err_q | beat_err;
               dec_d  = dec_q | ~in_range;
               if (last_beat) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            BVALID = 1'b1;
            if (BREADY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      resp = OKAY;
      if (dec_q) begin
         resp = DECERR;
      end else if (err_q) begin
         resp = SLVERR;
      end
   end

   assign BID   = id_q;
   assign BRESP = BW'(resp);

   // live_q holds AWREADY low while reset is asserted and releases it on the first clock after
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         dec_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         dec_q   <= dec_d;
         live_q  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: directed bursts against a behavioural memory/response model of axi_write_slave.
module tb_axi_write_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic        AWVALID, AWREADY;
   logic [3:0]  AWID, AWLEN;
   logic [31:0] AWADDR;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        WVALID, WREADY, WLAST;
   logic [3:0]  WID, WSTRB;
   logic [31:0] WDATA;
   logic        BVALID, BREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic [7:0]  dbg_addr;
   logic [31:0] dbg_rdata;

   always #5 clk = ~clk;

   axi_write_slave dut (
      .clk       (clk),
      .reset     (reset),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .AWID      (AWID),
      .AWADDR    (AWADDR),
      .AWLEN     (AWLEN),
      .AWSIZE    (AWSIZE),
      .AWBURST   (AWBURST),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .WID       (WID),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .WLAST     (WLAST),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .BID       (BID),
      .BRESP     (BRESP),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   int compared   = 0;
   int mismatched = 0;

   // expected handshake/response outputs and a byte-tracked memory model
   logic        exp_awready = 1'b0;
   logic        exp_wready  = 1'b0;
   logic        exp_bvalid  = 1'b0;
   logic [3:0]  exp_bid     = 4'h0;
   logic [1:0]  exp_bresp   = 2'b00;
   logic [31:0] mdl_mem   [256];
   logic [3:0]  mdl_known [256];
   logic [31:0] bdata [16];
   logic [3:0]  bstrb [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] m;
      if (reset) begin
         check("rst_awready", 32'(AWREADY), 32'h0);
         check("rst_wready",  32'(WREADY),  32'h0);
         check("rst_bvalid",  32'(BVALID),  32'h0);
         check("rst_bid",     32'(BID),     32'h0);
         check("rst_bresp",   32'(BRESP),   32'h0);
      end else begin
         check("awready", 32'(AWREADY), 32'(exp_awready));
         check("wready",  32'(WREADY),  32'(exp_wready));
         check("bvalid",  32'(BVALID),  32'(exp_bvalid));
         if (exp_bvalid) begin
            check("bid",   32'(BID),   32'(exp_bid));
            check("bresp", 32'(BRESP), 32'(exp_bresp));
         end
         if (mdl_known[dbg_addr] != 4'h0) begin
            for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{mdl_known[dbg_addr][b]}};
            check("dbg_rdata", dbg_rdata & m, mdl_mem[dbg_addr] & m);
         end
      end
   end

   task automatic check_word(input string name, input logic [7:0] idx, input logic [31:0] req,
                             input logic [31:0] mask);
      @(posedge clk);
      #2;
      dbg_addr = idx;
      #1;
      check(name, dbg_rdata & mask, req);
   endtask

   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_wid_beat,
                            input int early_last_beat, input int bready_wait, input int abort_after,
                            input logic [1:0] lit_resp);
      int          beats;
      logic        err, dec, berr;
      logic [31:0] bytes, win, base, baddr, wordi;
      beats = int'(len) + 1;
      bytes = 32'd1 << size;
      err   = (burst == 2'b11) || (size > 3'd2) ||
              ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
`ifndef AXI_WRAP_BURST_EN
      if (burst == 2'b10) err = 1'b1;
`endif
      dec = 1'b0;

      AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
      @(posedge clk);
      #1;
      AWVALID = 1'b0;
      exp_awready = 1'b0;
      exp_wready  = 1'b1;

      for (int k = 0; k < beats; k++) begin
         case (burst)
            2'b01:   baddr = addr + 32'(k) * bytes;
            2'b10: begin
               win   = 32'(beats) * bytes;
               base  = addr - (addr % win);
               baddr = base + ((addr - base + 32'(k) * bytes) % win);
            end
            default: baddr = addr;
         endcase
         WVALID = 1'b1;
         WID    = (k == bad_wid_beat) ? ~id : id;
         WDATA  = bdata[k];
         WSTRB  = bstrb[k];
         WLAST  = (k == beats - 1) || (k == early_last_beat);
         dbg_addr = baddr[9:2];
         @(posedge clk);
         #1;
         berr  = (WID != id) || (WLAST != (k == beats - 1));
         wordi = baddr >> 2;
         if (wordi >= 32'd256) begin
            dec = 1'b1;
         end else if (!err && !berr) begin
            for (int b = 0; b < 4; b++) begin
               if (bstrb[k][b]) begin
                  mdl_mem[wordi[7:0]][b*8 +: 8] = bdata[k][b*8 +: 8];
                  mdl_known[wordi[7:0]][b] = 1'b1;
               end
            end
         end
         if (berr) err = 1'b1;
         if (abort_after == k + 1) begin
            WVALID = 1'b0; WLAST = 1'b0; reset = 1'b1;
            exp_awready = 1'b0; exp_wready = 1'b0; exp_bvalid = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            @(posedge clk);
            #1 exp_awready = 1'b1;
            $display("burst id=%0h addr=%08h len=%0d type=%0d aborted by reset after %0d beats",
                     id, addr, len, burst, k + 1);
            return;
         end
      end

      WVALID = 1'b0; WLAST = 1'b0;
      exp_wready = 1'b0;
      exp_bvalid = 1'b1;
      exp_bid    = id;
      exp_bresp  = dec ? 2'b11 : (err ? 2'b10 : 2'b00);
      check("model_resp", 32'(exp_bresp), 32'(lit_resp));
      repeat (bready_wait) begin
         @(posedge clk);
         #1;
      end
      BREADY = 1'b1;
      @(posedge clk);
      #1;
      BREADY = 1'b0;
      exp_bvalid  = 1'b0;
      exp_awready = 1'b1;
      $display("burst id=%0h addr=%08h len=%0d type=%0d resp=%0d", id, addr, len, burst, exp_bresp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [1:0] wrap_resp;
      for (int i = 0; i < 256; i++) begin
         mdl_mem[i]   = 32'h0;
         mdl_known[i] = 4'h0;
      end
      reset = 1'b1;
      AWVALID = 1'b0; AWID = 4'h0; AWADDR = 32'h0; AWLEN = 4'h0; AWSIZE = 3'd0; AWBURST = 2'b00;
      WVALID = 1'b0; WID = 4'h0; WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0;
      BREADY = 1'b0; dbg_addr = 8'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 exp_awready = 1'b1;

      // INCR, four full-word beats into words 4..7
      for (int k = 0; k < 4; k++) begin
         bdata[k] = 32'hA0 + 32'(k);
         bstrb[k] = 4'hF;
      end
      run_burst(4'h3, 32'h10, 4'd3, 3'd2, 2'b01, -1, -1, 0, 0, 2'b00);
      check_word("s1_w4", 8'd4, 32'hA0, 32'hFFFF_FFFF);
      check_word("s1_w7", 8'd7, 32'hA3, 32'hFFFF_FFFF);

      // WRAP from 0x18 in a 16-byte window
      for (int k = 0; k < 4; k++) bdata[k] = 32'(k + 1);
`ifdef AXI_WRAP_BURST_EN
      wrap_resp = 2'b00;
`else
      wrap_resp = 2'b10;
`endif
      run_burst(4'h5, 32'h18, 4'd3, 3'd2, 2'b10, -1, -1, 0, 0, wrap_resp);
`ifdef AXI_WRAP_BURST_EN
      check_word("s2_w6", 8'd6, 32'h1, 32'hFFFF_FFFF);
      check_word("s2_w7", 8'd7, 32'h2, 32'hFFFF_FFFF);
      check_word("s2_w4", 8'd4, 32'h3, 32'hFFFF_FFFF);
      check_word("s2_w5", 8'd5, 32'h4, 32'hFFFF_FFFF);
`else
      check_word("s2_w6", 8'd6, 32'hA2, 32'hFFFF_FFFF);
      check_word("s2_w4", 8'd4, 32'hA0, 32'hFFFF_FFFF);
`endif

      // FIXED, byte lanes 0 then 1 of word 2
      bdata[0] = 32'h11;   bstrb[0] = 4'h1;
      bdata[1] = 32'h2200; bstrb[1] = 4'h2;
      run_burst(4'h6, 32'h8, 4'd1, 3'd2, 2'b00, -1, -1, 0, 0, 2'b00);
      check_word("s3_w2", 8'd2, 32'h2211, 32'h0000_FFFF);

      // INCR running off the end of memory
      bdata[0] = 32'h55; bstrb[0] = 4'hF;
      bdata[1] = 32'h66; bstrb[1] = 4'hF;
      run_burst(4'h7, 32'h3FC, 4'd1, 3'd2, 2'b01, -1, -1, 0, 0, 2'b11);
      check_word("s4_w255", 8'd255, 32'h55, 32'hFFFF_FFFF);

      // WID mismatch on beat 0, response held for 5 cycles
      bdata[0] = 32'h77; bstrb[0] = 4'hF;
      bdata[1] = 32'h88; bstrb[1] = 4'hF;
      run_burst(4'h9, 32'h8, 4'd1, 3'd2, 2'b01, 0, -1, 5, 0, 2'b10);
      check_word("s5_w2", 8'd2, 32'h2211, 32'h0000_FFFF);

      // reset after the second beat of a 4-beat burst
      for (int k = 0; k < 4; k++) begin
         bdata[k] = 32'hC0 + 32'(k);
         bstrb[k] = 4'hF;
      end
      run_burst(4'h2, 32'h80, 4'd3, 3'd2, 2'b01, -1, -1, 0, 2, 2'b00);
      check_word("s6_w32", 8'd32, 32'hC0, 32'hFFFF_FFFF);
      check_word("s6_w33", 8'd33, 32'hC1, 32'hFFFF_FFFF);

      // early WLAST on beat 0 does not end a 3-beat burst
      run_burst(4'h4, 32'hC0, 4'd2, 3'd2, 2'b01, -1, 0, 0, 0, 2'b10);

      // single clean beat after the error bursts
      bdata[0] = 32'hDEADBEEF; bstrb[0] = 4'hF;
      run_burst(4'h1, 32'h100, 4'd0, 3'd2, 2'b01, -1, -1, 0, 0, 2'b00);
      check_word("s8_w64", 8'd64, 32'hDEADBEEF, 32'hFFFF_FFFF);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/axi_write_slave.md
AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

Interface
REQ-001 Parameter WIDTH, default 32, data bus width in bits; strobe, ID and LEN fields are WIDTH/8 bits wide.
REQ-002 Parameter SIZE, default 3, AWSIZE width; AWBURST and BRESP are SIZE-1 bits wide.
REQ-003 Parameter DEPTH, default 256, number of WIDTH-bit memory words.
REQ-004 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-005 Ports:
- clk, in, 1: clock.
- reset, in, 1: async active-high reset.
- AWVALID, in, 1 / AWREADY, out, 1: address handshake.
- AWID, in, WIDTH/8: transaction ID.
- AWADDR, in, WIDTH: byte start address.
- AWLEN, in, WIDTH/8: beats minus 1.
- AWSIZE, in, SIZE: log2 bytes per beat.
- AWBURST, in, SIZE-1: burst type.
- WVALID, in, 1 / WREADY, out, 1: data handshake.
- WID, in, WIDTH/8: data ID.
- WDATA, in, WIDTH: write data.
- WSTRB, in, WIDTH/8: byte enables.
- WLAST, in, 1: final beat.
- BVALID, out, 1 / BREADY, in, 1: response handshake.
- BID, out, WIDTH/8: response ID.
- BRESP, out, SIZE-1: response code.
- dbg_addr, in, log2(DEPTH): memory word index.
- dbg_rdata, out, WIDTH: combinational read of that word.

Function
REQ-006 The FSM SHALL have three states: IDLE, DATA, RESP.
REQ-007 IDLE: AWREADY=1. On AWVALID, latch ID/ADDR/LEN/SIZE/BURST, clear the beat counter and error flag, and go to DATA next cycle.
REQ-008 DATA: WREADY=1. Each WVALID&&WREADY cycle is one beat; the beat counter increments.
REQ-009 An accepted beat SHALL write WDATA byte lanes enabled by WSTRB into word ADDR>>log2(WIDTH/8), but only when the error flag is clear.
REQ-010 Next address by burst type:
- FIXED (00): unchanged.
- INCR (01): ADDR + (1<<SIZE).
- WRAP (10): the address increments and wraps within an aligned window of (LEN+1)<<SIZE bytes.
REQ-011 The error flag SHALL be set, giving BRESP=SLVERR (10), on any of:
- BURST=11;
- AWSIZE > log2(WIDTH/8);
- WRAP with LEN not in {1,3,7,15};
- WID != latched ID on any beat;
- WLAST value differs from (counter==LEN).
REQ-012 Any beat whose word index is >= DEPTH SHALL set BRESP=DECERR (11); DECERR overrides SLVERR.
REQ-013 On the beat where counter==LEN, the FSM SHALL go to RESP. An early WLAST SHALL NOT end the burst.
REQ-014 RESP: BVALID=1, BID=latched ID, BRESP=OKAY (00) or the error code. Hold all three stable until BREADY, then return to IDLE.
REQ-015 BVALID&&BREADY SHALL return the FSM to IDLE, where AWREADY is 1 the next cycle; no new AW is accepted while in DATA or RESP.
REQ-016 Write latency: memory updated at the clock edge of the W handshake; BVALID asserts the cycle after the last beat.
REQ-017 Address arithmetic SHALL be WIDTH bits and wrap modulo 2^WIDTH for INCR.

Reset
REQ-018 Asserting reset SHALL force state IDLE and AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, and clear the counter, latched fields and error flag; memory contents are left unchanged.
REQ-019 Reset mid-burst SHALL abandon the burst without a B response; AWREADY=1 on the first clock after deassertion.

Configuration
REQ-020 Macro AXI_WRAP_BURST_EN:
- defined: WRAP behaves per REQ-010.
- undefined: WRAP bursts are accepted and consumed but write nothing, and return SLVERR.

Structure
REQ-021 Package axiprotocol SHALL hold:
- burst enum: FIXED, INCR, WRAP, RSVD;
- resp enum: OKAY, EXOKAY, SLVERR, DECERR;
- state enum: IDLE, DATA, RESP.
REQ-022 Sub-module axi_wr_addr_gen SHALL compute the next address combinationally from ADDR, LEN, SIZE and BURST.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- INCR, AWADDR=0x10, LEN=3, SIZE=2, WDATA 0xA0..0xA3, WSTRB=F -> words 4..7 = A0..A3; BRESP=00; BID=AWID.
- WRAP, AWADDR=0x18, LEN=3, SIZE=2, data 1,2,3,4 -> word 6=1, 7=2, 4=3, 5=4; BRESP=00 (SLVERR with no writes if macro undefined).
- FIXED, AWADDR=0x8, LEN=1, WSTRB=0x1 then 0x2, data 0x11, 0x2200 -> word 2 low half = 0x2211; BRESP=00.
- INCR, AWADDR=DEPTH*4-4, LEN=1 -> first beat written, second not; BRESP=11.
- WID mismatch on beat 0, BREADY held low 5 cycles -> BVALID, BID and BRESP=10 stable all 5 cycles; IDLE after BREADY.
- reset asserted after beat 1 of LEN=3 -> no BVALID; AWREADY=1 after deassertion; beat 0 write retained.
